// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and default constants for the alarm clock key logic.
//   key_state_e     - per-key debounce FSM states
//   KEY_STATE_W     - width of the FSM state encoding
//   DEF_*_TICKS     - default debounce / hold / repeat sample counts
//   max_u()         - helper used to size the per-key counter
package alarm_pkg;

    localparam int unsigned KEY_STATE_W = 2;

    localparam int unsigned DEF_STABLE_TICKS = 4;
    localparam int unsigned DEF_HOLD_TICKS   = 100;
    localparam int unsigned DEF_REPEAT_TICKS = 25;

    typedef enum logic [KEY_STATE_W-1:0] {
        StIdle,
        StPressChk,
        StHeld,
        StRelChk
    } key_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: debounces a single active-low pushbutton.
// Contains the 2-flop key synchronizer, the per-key FSM and its saturating counter.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   tick_i     one-cycle sample strobe; the FSM only advances on tick cycles
//   key_ni     raw key, 0 = pressed, asynchronous
//   level_o    registered debounced level, 1 = pressed
//   press_o    registered one-cycle pulse per confirmed press (and per repeat)
//   release_o  registered one-cycle pulse per confirmed release
// Build option: KEY_REPEAT_EN enables auto-repeat while the key stays held.
module key_debounce_cell
    import alarm_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic key_ni,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

`ifdef KEY_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    localparam int unsigned CntMax = max_u(STABLE_TICKS, HOLD_TICKS);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntSat     = cnt_t'(CntMax);
    localparam cnt_t StableLast = cnt_t'(STABLE_TICKS - 1);
    localparam cnt_t HoldLast   = cnt_t'(HOLD_TICKS - 1);
    // Reload so the next repeat pulse lands REPEAT_TICKS ticks after this one.
    localparam cnt_t RepeatLoad = cnt_t'(HOLD_TICKS - REPEAT_TICKS);

    logic [1:0] sync_q;
    logic       pressed;

    key_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d, cnt_inc;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Key synchronizer resets to "released".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_ni};
        end
    end

    assign pressed = ~sync_q[1];
    assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + cnt_t'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (tick_i) begin
            unique case (state_q)
                StIdle: begin
                    if (pressed) begin
                        state_d = StPressChk;
                        cnt_d   = cnt_t'(1);
                    end
                end
                StPressChk: begin
                    if (!pressed) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StHeld;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHeld: begin
                    if (!pressed) begin
                        state_d = StRelChk;
                        cnt_d   = cnt_t'(1);
                    end else if (RepeatEn) begin
                        if (cnt_q == HoldLast) begin
                            press_d = 1'b1;
                            cnt_d   = RepeatLoad;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                StRelChk: begin
                    if (pressed) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d   = StIdle;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: debounces KEY_NUM active-low pushbuttons for the alarm clock.
// SAMPLE_CLK is synchronized and edge-detected into a one-cycle tick; it is never used as a clock.
// Ports:
//   CLK_50M      system clock
//   nCLR         asynchronous active-low reset
//   SAMPLE_CLK   slow square wave from the clock divider (data)
//   key_n        raw pushbuttons, 0 = pressed
//   key_level    debounced levels, 1 = pressed
//   key_press    one-cycle press (and repeat) pulses
//   key_release  one-cycle release pulses
// Build option: KEY_REPEAT_EN enables auto-repeat in every key cell.
module key_debouncer
    import alarm_pkg::*;
#(
    parameter int unsigned KEY_NUM      = 4,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic               CLK_50M,
    input  logic               nCLR,
    input  logic               SAMPLE_CLK,
    input  logic [KEY_NUM-1:0] key_n,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release
);

    // [1:0] synchronizer, [2] previous value for rising-edge detection.
    logic [2:0] samp_q;
    logic       tick;

    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            samp_q <= 3'b000;
        end else begin
            samp_q <= {samp_q[1:0], SAMPLE_CLK};
        end
    end

    assign tick = samp_q[1] & ~samp_q[2];

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_cell (
            .clk_i     (CLK_50M),
            .rst_ni    (nCLR),
            .tick_i    (tick),
            .key_ni    (key_n[i]),
            .level_o   (key_level[i]),
            .press_o   (key_press[i]),
            .release_o (key_release[i])
        );
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounces the alarm clock's active-low pushbuttons and turns each into clean one-cycle press/release events plus a stable level. Sits directly downstream of the 50 Hz-class clock divider: it runs on the 50 MHz board clock and uses the divider's slow square-wave output only as a sample strobe. Its outputs feed the time-setting and alarm control logic.

## Interface
- KEY_NUM, 4: number of independent keys.
- STABLE_TICKS, 4: consecutive agreeing samples needed to change the debounced state; legal range is ≥2.
- HOLD_TICKS, 100: samples held before auto-repeat starts (KEY_REPEAT_EN only).
- REPEAT_TICKS, 25: samples between repeat pulses (KEY_REPEAT_EN only).

Ports (one clock; reset is asynchronous and active-low):
- CLK_50M  in  1  system clock; all flops.
- nCLR  in  1  asynchronous active-low reset.
- SAMPLE_CLK  in  1  divided slow clock from the divider; treated as data, never as a clock.
- key_n  in  KEY_NUM  raw pushbuttons; 0 = pressed; asynchronous.
- key_level  out  KEY_NUM  debounced state; 1 = pressed.
- key_press  out  KEY_NUM  one-cycle pulse per confirmed press (and per repeat).
- key_release  out  KEY_NUM  one-cycle pulse per confirmed release.

## Operation
- **Sample tick:** SAMPLE_CLK passes through a 2-flop synchronizer and then a rising-edge detector. This produces `tick`, one CLK_50M cycle per SAMPLE_CLK period.
- **Key synchronizer:** each key_n bit passes through a 2-flop synchronizer (reset value 1). The sampled value is `p = ~sync`. Key inputs are evaluated only on `tick` cycles.
- **Per-key FSM (states IDLE, PRESS_CHK, HELD, REL_CHK):** holds a counter `cnt` sized for max(STABLE_TICKS, HOLD_TICKS).
  - IDLE, tick, p=1: go to PRESS_CHK, cnt=1.
  - PRESS_CHK, tick, p=0: return to IDLE, cnt=0. This is how bounce is rejected.
  - PRESS_CHK, tick, p=1: if cnt==STABLE_TICKS-1, go to HELD, set key_level=1, pulse key_press, cnt=0. Otherwise cnt+1.
  - HELD, tick, p=0: go to REL_CHK, cnt=1.
  - REL_CHK, tick, p=1: return to HELD. The hold counter restarts at 0.
  - REL_CHK, tick, p=0: if cnt==STABLE_TICKS-1, go to IDLE, set key_level=0, pulse key_release, cnt=0. Otherwise cnt+1.
- **Independence:** keys are fully independent. Simultaneous events on several keys produce simultaneous pulses.
- **Non-tick cycles:** no state or counter changes.
- **Counter width:** counters saturate and never wrap.

## Timing
- **Reset values:** all outputs are 0. All FSMs are in IDLE with cnt=0. Key sync flops reset to 1; SAMPLE_CLK sync and edge flops reset to 0.
- **Reset mid-operation:** asserting nCLR while HELD drops key_level immediately and does not emit key_release.
- **Output registers:** all outputs are registered. A pulse is high exactly for the CLK_50M cycle after the deciding tick cycle. key_level changes in that same cycle.
- **Input latency:** a raw key edge is visible to the FSM 2 cycles later. tick follows a SAMPLE_CLK rising edge by 3 cycles.
- **Press latency:** minimum press is STABLE_TICKS ticks after the first pressed sample, i.e. (STABLE_TICKS-1) SAMPLE_CLK periods plus sync delay.
- **No coincident pulses:** key_press and key_release are never high together for the same key.

## Configuration
- **KEY_REPEAT_EN defined:** in HELD, cnt counts ticks.
  - When cnt reaches HOLD_TICKS, key_press pulses and cnt reloads so that the next pulse comes REPEAT_TICKS ticks later. This repeats while held.
  - Leaving HELD cancels repeat.
- **KEY_REPEAT_EN undefined:** HELD ignores pressed ticks, so exactly one key_press occurs per press. HOLD_TICKS and REPEAT_TICKS are unused.

## Structure
- **Package `alarm_pkg`:** key FSM state enum (IDLE, PRESS_CHK, HELD, REL_CHK), the 2-bit state width constant, and the default STABLE_TICKS/HOLD_TICKS/REPEAT_TICKS constants.
- **Sub-module `key_debounce_cell`:** one instance per key, generated KEY_NUM times. It contains the synchronizer, FSM and counter.
- **Top level:** owns the shared SAMPLE_CLK synchronizer and tick generator.

## Test plan
Bench drives SAMPLE_CLK with a 20-cycle period and uses default parameters.
- **Clean press:** key_n[0] held low for 10 ticks -> key_press[0] is one cycle high exactly once, the cycle after the 4th pressed tick. key_level[0] goes to 1.
- **Bounce:** key_n[1] alternates low/high each tick for 8 ticks, then stays high -> no key_press[1] and key_level[1] stays 0. A pattern of 3 low ticks, 1 high, then 4 low -> a single press on the 4th tick of the final run.
- **Release:** release key 0 after the clean press -> key_release[0] one cycle after the 4th released tick; key_level[0] goes to 0. A release glitch of 2 ticks produces no release.
- **Simultaneous:** keys 2 and 3 pressed in the same cycle -> key_press[3:2]=2'b11 in the same cycle.
- **Reset mid-hold:** pull nCLR low while key 0 is HELD -> all outputs go to 0 asynchronously and no key_release. After nCLR is released with the key still held, a new press is confirmed 4 ticks later.
- **Repeat (KEY_REPEAT_EN):** hold key 0 for 200 ticks -> first pulse at tick 4, second at tick 104, then every 25 ticks (129, 154, 179). Without KEY_REPEAT_EN, only the tick-4 pulse.
